// File: rtl/alu_issue_stage.sv
// ALU issue stage: operand select plus 2-entry skid buffer ahead of ALUSubmodule.
// Optional writeback forwarding at capture: define ALU_ISSUE_FORWARD_EN.
package alu_issue_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } ALUOperation;
endpackage

module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REGIDX_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  ALUOperation         in_op,
    input  logic [XLEN-1:0]     in_rs1_val,
    input  logic [XLEN-1:0]     in_rs2_val,
    input  logic [XLEN-1:0]     in_imm,
    input  logic [XLEN-1:0]     in_pc,
    input  logic                in_a_sel,
    input  logic                in_b_sel,
    input  logic [REGIDX_W-1:0] in_rs1_idx,
    input  logic [REGIDX_W-1:0] in_rs2_idx,
    input  logic [REGIDX_W-1:0] in_rd,
    input  logic                wb_valid,
    input  logic [REGIDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output ALUOperation         op,
    output logic [XLEN-1:0]     A,
    output logic [XLEN-1:0]     B,
    output logic [REGIDX_W-1:0] out_rd
);

    typedef struct packed {
        ALUOperation         op;
        logic [XLEN-1:0]     a;
        logic [XLEN-1:0]     b;
        logic [REGIDX_W-1:0] rd;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t   state_q, state_d;
    entry_t main_q, skid_q, cap;
    logic   rdy_q;
    logic   accept, transfer;
    logic   load_main_cap, load_main_skid, load_skid;
    logic [XLEN-1:0] rs1, rs2;

`ifdef ALU_ISSUE_FORWARD_EN
    logic fwd1, fwd2;
    assign fwd1 = wb_valid && (wb_rd != '0) && (wb_rd == in_rs1_idx);
    assign fwd2 = wb_valid && (wb_rd != '0) && (wb_rd == in_rs2_idx);
    assign rs1  = fwd1 ? wb_data : in_rs1_val;
    assign rs2  = fwd2 ? wb_data : in_rs2_val;
`else
    logic unused_fwd;
    assign unused_fwd = ^{wb_valid, wb_rd, wb_data, in_rs1_idx, in_rs2_idx};
    assign rs1 = in_rs1_val;
    assign rs2 = in_rs2_val;
`endif

    assign cap.op = in_op;
    assign cap.a  = in_a_sel ? in_pc : rs1;
    assign cap.b  = in_b_sel ? in_imm : rs2;
    assign cap.rd = in_rd;

    assign accept   = in_valid && rdy_q;
    assign transfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !transfer)      state_d = TWO;
                    else if (!accept && transfer) state_d = EMPTY;
                end
                TWO:     if (transfer) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Flush suppresses every load so the held outputs stay untouched.
    always_comb begin
        load_main_cap  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush) begin
            unique case (1'b1)
                state_q == EMPTY: load_main_cap = accept;
                state_q == ONE: begin
                    load_main_cap = accept && transfer;
                    load_skid     = accept && !transfer;
                end
                state_q == TWO: load_main_skid = transfer;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '{op: ALU_ADD, a: '0, b: '0, rd: '0};
            skid_q <= '{op: ALU_ADD, a: '0, b: '0, rd: '0};
        end else begin
            if (load_main_cap)       main_q <= cap;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= cap;
        end
    end

    always_comb begin
        in_ready  = rdy_q;
        out_valid = (state_q != EMPTY);
        op        = main_q.op;
        A         = main_q.a;
        B         = main_q.b;
        out_rd    = main_q.rd;
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: vector table, corner sequences,
// and a randomized run against a queue-based reference model.
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    ALUOperation in_op, op;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_pc, wb_data, A, B;
    logic        in_a_sel, in_b_sel, wb_valid, out_valid, out_ready;
    logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd, wb_rd, out_rd;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_pc(in_pc),
        .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd(in_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .A(A), .B(B), .out_rd(out_rd)
    );

    typedef struct {
        ALUOperation op;
        logic [31:0] rs1, rs2, imm, pc;
        logic        asel, bsel;
        logic [4:0]  i1, i2, rd;
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic [31:0] ea, eb;
    } vec_t;

    typedef struct {
        ALUOperation op;
        logic [31:0] a, b;
        logic [4:0]  rd;
    } ent_t;

    vec_t vt[7];
    ent_t q[$];
    ent_t shown;
    logic mrdy;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
        in_op = ALU_ADD; in_rs1_val = 0; in_rs2_val = 0; in_imm = 0;
        in_pc = 0; in_a_sel = 0; in_b_sel = 0;
        in_rs1_idx = 0; in_rs2_idx = 0; in_rd = 0;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1; in_op = v.op; in_rs1_val = v.rs1; in_rs2_val = v.rs2;
        in_imm = v.imm; in_pc = v.pc; in_a_sel = v.asel; in_b_sel = v.bsel;
        in_rs1_idx = v.i1; in_rs2_idx = v.i2; in_rd = v.rd;
        wb_valid = v.wv; wb_rd = v.wrd; wb_data = v.wdata;
    endtask

    // Simple tagged instruction: rs1 value doubles as its identity.
    function automatic vec_t tag(input logic [31:0] id);
        vec_t v;
        v = '{op: ALU_XOR, rs1: id, rs2: id + 1, imm: 0, pc: 0,
              asel: 0, bsel: 0, i1: 0, i2: 0, rd: id[4:0],
              wv: 0, wrd: 0, wdata: 0, ea: id, eb: id + 1};
        return v;
    endfunction

    function automatic logic fwd_hit(input logic wv, input logic [4:0] wrd,
                                     input logic [4:0] idx);
`ifdef ALU_ISSUE_FORWARD_EN
        return wv && wrd != 0 && wrd == idx;
`else
        return 1'b0;
`endif
    endfunction

    function automatic ent_t model_cap();
        ent_t e;
        logic [31:0] r1, r2;
        r1 = fwd_hit(wb_valid, wb_rd, in_rs1_idx) ? wb_data : in_rs1_val;
        r2 = fwd_hit(wb_valid, wb_rd, in_rs2_idx) ? wb_data : in_rs2_val;
        e.op = in_op;
        e.a  = in_a_sel ? in_pc : r1;
        e.b  = in_b_sel ? in_imm : r2;
        e.rd = in_rd;
        return e;
    endfunction

    task automatic chk_out(input string nm, input logic v, input ent_t e);
        chk({nm, ".valid"}, 32'(out_valid), 32'(v));
        chk({nm, ".op"}, 32'(op), 32'(e.op));
        chk({nm, ".A"}, A, e.a);
        chk({nm, ".B"}, B, e.b);
        chk({nm, ".rd"}, 32'(out_rd), 32'(e.rd));
    endtask

    function automatic ent_t ent_of(input vec_t v);
        ent_t e;
        e = '{op: v.op, a: v.ea, b: v.eb, rd: v.rd};
        return e;
    endfunction

    initial begin
        ent_t rz;
        rz = '{op: ALU_ADD, a: 0, b: 0, rd: 0};

        vt[0] = '{ALU_ADD, 5, 7, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 5, 7};
        vt[1] = '{ALU_SUB, 9, 9, 32'hFFFFFFFC, 32'h100, 1, 1, 0, 0, 1,
                  0, 0, 0, 32'h100, 32'hFFFFFFFC};
        vt[2] = '{ALU_SLL, 32'h80000001, 0, 33, 0, 0, 1, 0, 0, 7,
                  0, 0, 0, 32'h80000001, 33};
        vt[3] = '{ALU_ADD, 1, 2, 0, 0, 0, 0, 4, 0, 8, 1, 4, 32'hDEAD, 0, 2};
        vt[4] = '{ALU_ADD, 1, 2, 0, 0, 0, 0, 0, 0, 8, 1, 0, 32'hDEAD, 1, 2};
        vt[5] = '{ALU_OR, 3, 6, 0, 0, 0, 0, 0, 9, 2, 1, 9, 32'h1234, 3, 0};
        vt[6] = '{ALU_AND, 1, 2, 0, 32'h44, 1, 0, 4, 0, 31,
                  1, 4, 32'hBEEF, 32'h44, 2};
`ifdef ALU_ISSUE_FORWARD_EN
        vt[3].ea = 32'hDEAD;
        vt[5].eb = 32'h1234;
`else
        vt[3].ea = 1;
        vt[5].eb = 6;
`endif

        // Reset state
        idle(); out_ready = 1; rst = 1;
        repeat (2) @(negedge clk);
        chk_out("reset", 0, rz);
        chk("reset.in_ready", 32'(in_ready), 0);
        rst = 0;
        @(negedge clk);
        chk("post_reset.in_ready", 32'(in_ready), 1);
        chk("post_reset.valid", 32'(out_valid), 0);

        // Vector table, one instruction per cycle, out_ready high
        for (int i = 0; i < 7; i++) begin
            drive(vt[i]);
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), 1, ent_of(vt[i]));
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 1);
        end
        idle();
        @(negedge clk);
        chk_out("drain_hold", 0, ent_of(vt[6]));

        // Backpressure: three offered, two accepted, drained in order
        out_ready = 0;
        drive(tag(11));
        @(negedge clk);
        chk("bp1.in_ready", 32'(in_ready), 1);
        drive(tag(12));
        @(negedge clk);
        chk("bp2.in_ready", 32'(in_ready), 0);
        chk_out("bp2", 1, ent_of(tag(11)));
        drive(tag(13));
        @(negedge clk);
        chk("bp3.in_ready", 32'(in_ready), 0);
        chk_out("bp3", 1, ent_of(tag(11)));
        out_ready = 1;
        @(negedge clk);
        chk_out("bp_drain2", 1, ent_of(tag(12)));
        chk("bp_drain2.in_ready", 32'(in_ready), 1);
        @(negedge clk);
        chk_out("bp_drain3", 1, ent_of(tag(13)));
        idle();
        @(negedge clk);
        chk_out("bp_empty", 0, ent_of(tag(13)));

        // Flush in TWO with simultaneous in_valid
        out_ready = 0;
        drive(tag(21));
        @(negedge clk);
        drive(tag(22));
        @(negedge clk);
        drive(tag(23)); flush = 1;
        @(negedge clk);
        idle();
        chk_out("flush_two", 0, ent_of(tag(21)));
        chk("flush_two.in_ready", 32'(in_ready), 1);
        out_ready = 1;
        @(negedge clk);
        chk("flush_two.after", 32'(out_valid), 0);

        // Flush in ONE discards an accept that really is offered
        out_ready = 0;
        drive(tag(24));
        @(negedge clk);
        drive(tag(25)); flush = 1;
        @(negedge clk);
        idle();
        chk_out("flush_one", 0, ent_of(tag(24)));
        chk("flush_one.in_ready", 32'(in_ready), 1);

        // Reset mid-stream with two buffered
        drive(tag(26));
        @(negedge clk);
        drive(tag(27));
        @(negedge clk);
        idle(); rst = 1;
        @(negedge clk);
        chk_out("rst_mid", 0, rz);
        chk("rst_mid.in_ready", 32'(in_ready), 0);
        rst = 0; out_ready = 1;
        @(negedge clk);
        chk("rst_mid.after_ready", 32'(in_ready), 1);
        chk("rst_mid.after_valid", 32'(out_valid), 0);

        // Randomized run against FIFO model (depth 2)
        q.delete();
        shown = rz;
        mrdy = 1;
        for (int n = 0; n < 3000; n++) begin
            logic acc, xfer;
            chk("rnd.valid", 32'(out_valid), 32'(q.size() != 0));
            chk("rnd.in_ready", 32'(in_ready), 32'(mrdy));
            chk("rnd.op", 32'(op), 32'(shown.op));
            chk("rnd.A", A, shown.a);
            chk("rnd.B", B, shown.b);
            chk("rnd.rd", 32'(out_rd), 32'(shown.rd));
            if (failed > 20) break;
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            in_op      = ALUOperation'($urandom_range(0, 9));
            in_rs1_val = $urandom; in_rs2_val = $urandom;
            in_imm     = $urandom; in_pc = $urandom;
            in_a_sel   = 1'($urandom); in_b_sel = 1'($urandom);
            in_rs1_idx = 5'($urandom_range(0, 3));
            in_rs2_idx = 5'($urandom_range(0, 3));
            in_rd      = 5'($urandom);
            wb_valid   = 1'($urandom);
            wb_rd      = 5'($urandom_range(0, 3));
            wb_data    = $urandom;
            acc  = in_valid && mrdy;
            xfer = (q.size() != 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (xfer) void'(q.pop_front());
                if (acc) q.push_back(model_cap());
            end
            if (q.size() != 0) shown = q[0];
            mrdy = (q.size() < 2);
            @(negedge clk);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of ALUSubmodule in the RV32 execute path.
- Accepts decoded instructions over a valid/ready handshake and selects ALU operands: A from rs1 or PC, B from rs2 or immediate.
- Registers the result and drives the ALU op/A/B inputs plus destination tag.
- Contains a 2-entry skid buffer so in_ready is fully registered, plus a synchronous flush for branch redirects.

Parameters:
XLEN, 32, operand/data width; must match ALUSubmodule (32).
REGIDX_W, 5, register index width.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  discard all buffered entries this cycle.
in_valid  input  1  decoded instruction present.
in_ready  output  1  stage can accept this cycle.
in_op  input  ALUOperation  ALU operation (typedefs).
in_rs1_val  input  XLEN  rs1 register value.
in_rs2_val  input  XLEN  rs2 register value.
in_imm  input  XLEN  sign-extended immediate.
in_pc  input  XLEN  instruction PC.
in_a_sel  input  1  0=rs1, 1=PC.
in_b_sel  input  1  0=rs2, 1=imm.
in_rs1_idx  input  REGIDX_W  rs1 index (forwarding).
in_rs2_idx  input  REGIDX_W  rs2 index (forwarding).
in_rd  input  REGIDX_W  destination index.
wb_valid  input  1  writeback port valid (forwarding).
wb_rd  input  REGIDX_W  writeback index.
wb_data  input  XLEN  writeback data.
out_valid  output  1  op/A/B/out_rd valid to ALU.
out_ready  input  1  downstream consumes this cycle.
op  output  ALUOperation  to ALUSubmodule.op.
A  output  XLEN  to ALUSubmodule.A.
B  output  XLEN  to ALUSubmodule.B.
out_rd  output  REGIDX_W  destination tag travelling with result.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: out_valid=0, in_ready=0 while rst high, then 1 from the first cycle after rst falls; op=ALU_ADD, A=0, B=0, out_rd=0; both entries empty.
- Operand select (combinational, at capture):
  - A = in_a_sel ? in_pc : rs1.
  - B = in_b_sel ? in_imm : rs2.
  - Full XLEN is passed; the ALU uses B[4:0] for shifts. No truncation here.
- Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
- Outputs are driven only from the main register. The skid register holds overflow.
- Latency: an accepted instruction appears on outputs the next cycle when the buffer was empty, i.e. 1-cycle minimum, 1 instruction/cycle sustained.
- State = occupancy:
  - EMPTY: accept -> ONE (main loaded).
  - ONE: accept & transfer -> ONE (main reloaded). Accept & !transfer -> TWO (skid loaded). Transfer & !accept -> EMPTY.
  - TWO: transfer -> ONE (skid moves to main). No accept is possible.
- in_ready is registered: 1 iff next state != TWO. It is never combinationally dependent on out_ready.
- Ordering strictly FIFO. In TWO, the skid entry is always older than any new input.
- Output stability: while out_valid & !out_ready, op/A/B/out_rd are held constant.
- When EMPTY, op/A/B/out_rd hold their last values. out_valid=0.
- flush: highest priority. Next state EMPTY, out_valid=0 next cycle, any same-cycle accept discarded. A same-cycle transfer still completes downstream (already consumed).
- in_ready is 1 the cycle after flush.
- rst mid-operation overrides flush and all handshakes. All state returns to reset values next cycle.

Optional Feature:
- Macro: ALU_ISSUE_FORWARD_EN.
- Defined: at capture, if wb_valid & wb_rd!=0 & wb_rd==in_rs1_idx, rs1=wb_data, else in_rs1_val. rs2 is handled identically with in_rs2_idx.
  - Forwarding applies only at capture; buffered entries are not patched.
  - PC/imm selection is unaffected.
- Not defined: rs1=in_rs1_val, rs2=in_rs2_val. wb_* ports exist but are ignored.

Test Plan:
- Basic pass: rst then in_valid with in_op=ALU_ADD, rs1=5, rs2=7, a_sel=b_sel=0, rd=3, out_ready=1.
  -> Next cycle out_valid=1, op=ALU_ADD, A=5, B=7, out_rd=3. The ALU out is 12.
- Operand select: in_op=ALU_SUB, a_sel=1, pc=0x100, b_sel=1, imm=0xFFFFFFFC.
  -> A=0x100, B=0xFFFFFFFC.
- Backpressure: stream 3 instructions with out_ready=0.
  -> Two are accepted. in_ready=0 the cycle after the second accept.
  -> Outputs hold the first entry.
  -> Raising out_ready drains in order 1,2, then accepts the third. No loss or duplication.
- Flush in TWO with a simultaneous in_valid.
  -> Next cycle out_valid=0, in_ready=1. The flushed entries and the new input never appear.
- Reset mid-stream: assert rst with 2 entries buffered.
  -> Next cycle out_valid=0, op=ALU_ADD, A=B=0, in_ready=0 until rst falls.
- Forwarding (ALU_ISSUE_FORWARD_EN): in_rs1_idx=4, in_rs1_val=1, wb_valid=1, wb_rd=4, wb_data=0xDEAD.
  -> A=0xDEAD.
  -> Same stimulus with wb_rd=0 -> A=1.
  -> Without the macro -> A=1.
